// File: rtl/dram_cmd_responder_if.sv
// dram_cmd_responder_if: command/response bundle between DRAM controller and target model.
// Stat counters appear only when DRAM_RESP_STATS_EN is defined.
interface dram_cmd_responder_if #(
  parameter int NUM_BANKS = 4,
  parameter int ROW_W     = 16,
  parameter int COL_W     = 10
);
  logic                         cmd_valid;
  logic [1:0]                   cmd_op;
  logic                         cmd_we;
  logic [$clog2(NUM_BANKS)-1:0] cmd_bank;
  logic [ROW_W-1:0]             cmd_row;
  logic [COL_W-1:0]             cmd_col;
  logic                         rd_valid;
  logic [63:0]                  rd_data;
  logic                         rd_last;
  logic                         err_valid;
  logic [1:0]                   err_code;
`ifdef DRAM_RESP_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_err;
  modport master (output cmd_valid, cmd_op, cmd_we, cmd_bank, cmd_row, cmd_col,
                  input rd_valid, rd_data, rd_last, err_valid, err_code, stat_rd, stat_wr, stat_err);
  modport slave (input cmd_valid, cmd_op, cmd_we, cmd_bank, cmd_row, cmd_col,
                 output rd_valid, rd_data, rd_last, err_valid, err_code, stat_rd, stat_wr, stat_err);
`else
  modport master (output cmd_valid, cmd_op, cmd_we, cmd_bank, cmd_row, cmd_col,
                  input rd_valid, rd_data, rd_last, err_valid, err_code);
  modport slave (input cmd_valid, cmd_op, cmd_we, cmd_bank, cmd_row, cmd_col,
                 output rd_valid, rd_data, rd_last, err_valid, err_code);
`endif
endinterface

// File: rtl/dram_cmd_responder.sv
// dram_cmd_responder: DRAM target model tracking bank timing and returning read bursts.
// Define DRAM_RESP_STATS_EN to add saturating read/write/error counters.
module dram_cmd_responder #(
  parameter int NUM_BANKS = 4,
  parameter int ROW_W     = 16,
  parameter int COL_W     = 10,
  parameter int TRP       = 4,
  parameter int TRCD      = 4,
  parameter int TRAS      = 10,
  parameter int TCL       = 5,
  parameter int TCCD      = 4,
  parameter int BL        = 4
) (
  input logic clk,
  input logic rst_n,
  dram_cmd_responder_if.slave c
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int MT = TRAS > TRP ? (TRAS > TRCD ? (TRAS > TCCD ? TRAS : TCCD) : (TRCD > TCCD ? TRCD : TCCD))
                                 : (TRP > TRCD ? (TRP > TCCD ? TRP : TCCD) : (TRCD > TCCD ? TRCD : TCCD));
  localparam int CW = $clog2(MT + 1);
  localparam int RW = $clog2(BL + 1);
  typedef enum logic [1:0] {OP_NOP, OP_PRE, OP_ACT, OP_RDWR} op_t;
  logic             bank_open [NUM_BANKS];
  logic [15:0]      open_row  [NUM_BANKS];
  logic [CW-1:0]    rcd [NUM_BANKS];
  logic [CW-1:0]    ras [NUM_BANKS];
  logic [CW-1:0]    rp  [NUM_BANKS];
  logic [CW-1:0]    ccd;
  logic             dl_v [TCL];
  logic [63:0]      dl_d [TCL];
  logic [63:0]      beat;
  logic [RW-1:0]    rem;
  logic [BW-1:0]    b;
  logic [1:0]       code;
  logic             cmd, acc, rd_acc, st;
  always_comb begin
    b = c.cmd_bank;
    cmd = c.cmd_valid && c.cmd_op != OP_NOP;
    code = c.cmd_op == OP_ACT  ? (bank_open[b] ? 2'd1 : rp[b] != '0 ? 2'd2 : 2'd0)
         : c.cmd_op == OP_PRE  ? (bank_open[b] && ras[b] != '0 ? 2'd2 : 2'd0)
         : c.cmd_op == OP_RDWR ? (!bank_open[b] ? 2'd1 : (rcd[b] != '0 || ccd != '0) ? 2'd2 : 2'd0)
         : 2'd0;
    acc = cmd && code == 2'd0;
    rd_acc = acc && c.cmd_op == OP_RDWR && !c.cmd_we;
    st = dl_v[TCL-1];
  end
  // First beat comes straight from the delay line so back-to-back bursts abut without a gap.
  assign c.rd_valid = st || rem != '0;
  assign c.rd_data  = st ? dl_d[TCL-1] : beat;
  assign c.rd_last  = st ? (BL == 1) : rem == RW'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_open[i] <= 1'b0;
        open_row[i] <= '0;
        rcd[i] <= '0;
        ras[i] <= '0;
        rp[i] <= '0;
      end
      for (int i = 0; i < TCL; i++) begin
        dl_v[i] <= 1'b0;
        dl_d[i] <= '0;
      end
      ccd <= '0;
      beat <= '0;
      rem <= '0;
      c.err_valid <= 1'b0;
      c.err_code <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        rcd[i] <= rcd[i] - CW'(rcd[i] != '0);
        ras[i] <= ras[i] - CW'(ras[i] != '0);
        rp[i] <= rp[i] - CW'(rp[i] != '0);
      end
      ccd <= ccd - CW'(ccd != '0);
      if (acc && c.cmd_op == OP_ACT) begin
        bank_open[b] <= 1'b1;
        open_row[b] <= 16'(c.cmd_row);
        rcd[b] <= CW'(TRCD - 1);
        ras[b] <= CW'(TRAS - 1);
      end
      if (acc && c.cmd_op == OP_PRE && bank_open[b]) begin
        bank_open[b] <= 1'b0;
        rp[b] <= CW'(TRP - 1);
      end
      if (acc && c.cmd_op == OP_RDWR) ccd <= CW'(TCCD - 1);
      dl_v[0] <= rd_acc;
      dl_d[0] <= {24'b0, 8'(b), open_row[b], 6'b0, 10'(c.cmd_col)};
      for (int i = 1; i < TCL; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_d[i] <= dl_d[i-1];
      end
      beat <= st ? dl_d[TCL-1] + 64'd1 : beat + 64'd1;
      rem <= st ? RW'(BL - 1) : rem - RW'(rem != '0);
      c.err_valid <= cmd && code != 2'd0;
      c.err_code <= cmd ? code : 2'd0;
    end
  end
`ifdef DRAM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c.stat_rd <= '0;
      c.stat_wr <= '0;
      c.stat_err <= '0;
    end else begin
      if (rd_acc && c.stat_rd != '1) c.stat_rd <= c.stat_rd + 16'd1;
      if (acc && c.cmd_op == OP_RDWR && c.cmd_we && c.stat_wr != '1) c.stat_wr <= c.stat_wr + 16'd1;
      if (cmd && !acc && c.stat_err != '1) c.stat_err <= c.stat_err + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dram_cmd_responder.sv
// tb_dram_cmd_responder: directed checks of bank timing, errors and read bursts.
module tb_dram_cmd_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  dram_cmd_responder_if bus ();
  dram_cmd_responder dut (.clk(clk), .rst_n(rst_n), .c(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic chk_rd(string tag, logic v, logic [63:0] d, logic l);
    chk({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'(v));
    chk({tag, ".rd_last"}, 64'(bus.rd_last), 64'(l));
    if (v) chk({tag, ".rd_data"}, bus.rd_data, d);
  endtask
  task automatic chk_err(string tag, logic v, logic [1:0] code);
    chk({tag, ".err_valid"}, 64'(bus.err_valid), 64'(v));
    chk({tag, ".err_code"}, 64'(bus.err_code), 64'(code));
  endtask
  task automatic drive(logic v, logic [1:0] op, logic we, logic [1:0] bank, logic [15:0] row, logic [9:0] col);
    bus.cmd_valid = v;
    bus.cmd_op = op;
    bus.cmd_we = we;
    bus.cmd_bank = bank;
    bus.cmd_row = row;
    bus.cmd_col = col;
    @(negedge clk);
  endtask
  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 2'd0, 16'h0, 10'h0);
  endtask
  initial begin
    int o;
    logic v;
    logic [63:0] d;
    idle();
    idle();
    chk_err("reset", 1'b0, 2'd0);
    chk_rd("reset", 1'b0, 64'h0, 1'b0);
    rst_n = 1'b1;
    // single read: ACT t0, RD t4, beats t9..t12
    for (int c = 0; c <= 13; c++) begin
      if (c == 0) drive(1'b1, 2'd2, 1'b0, 2'd0, 16'h1234, 10'h0);
      else if (c == 4) drive(1'b1, 2'd3, 1'b0, 2'd0, 16'h0, 10'h010);
      else idle();
      o = c + 1;
      v = o >= 9 && o <= 12;
      chk_err("rd1", 1'b0, 2'd0);
      chk_rd("rd1", v, 64'h0000_0000_1234_0010 + 64'(o - 9), o == 12);
    end
    // early RD after ACT is a timing error; retry one cycle later succeeds
    for (int c = 0; c <= 13; c++) begin
      if (c == 0) drive(1'b1, 2'd2, 1'b0, 2'd1, 16'hABCD, 10'h0);
      else if (c == 3 || c == 4) drive(1'b1, 2'd3, 1'b0, 2'd1, 16'h0, 10'h005);
      else idle();
      o = c + 1;
      v = o >= 9 && o <= 12;
      chk_err("rcd", o == 4, o == 4 ? 2'd2 : 2'd0);
      chk_rd("rcd", v, 64'h0000_0001_ABCD_0005 + 64'(o - 9), o == 12);
    end
    // state errors on bank 2
    drive(1'b1, 2'd3, 1'b0, 2'd2, 16'h0, 10'h0);
    chk_err("rd_closed", 1'b1, 2'd1);
    drive(1'b1, 2'd1, 1'b0, 2'd2, 16'h0, 10'h0);
    chk_err("pre_closed", 1'b0, 2'd0);
    drive(1'b1, 2'd2, 1'b0, 2'd2, 16'h0007, 10'h0);
    chk_err("act_b2", 1'b0, 2'd0);
    drive(1'b1, 2'd2, 1'b0, 2'd2, 16'h0007, 10'h0);
    chk_err("act_open", 1'b1, 2'd1);
    idle();
    chk_err("idle", 1'b0, 2'd0);
    drive(1'b1, 2'd1, 1'b0, 2'd0, 16'h0, 10'h0);
    chk_err("pre_b0", 1'b0, 2'd0);
    drive(1'b1, 2'd1, 1'b0, 2'd1, 16'h0, 10'h0);
    chk_err("pre_b1", 1'b0, 2'd0);
    repeat (4) idle();
    // tRAS and tRP edges on bank 0
    for (int c = 0; c <= 14; c++) begin
      if (c == 0 || c == 13 || c == 14) drive(1'b1, 2'd2, 1'b0, 2'd0, 16'h0042, 10'h0);
      else if (c == 9 || c == 10) drive(1'b1, 2'd1, 1'b0, 2'd0, 16'h0, 10'h0);
      else idle();
      o = c + 1;
      chk_err("ras_rp", o == 10 || o == 14, (o == 10 || o == 14) ? 2'd2 : 2'd0);
      chk_rd("ras_rp", 1'b0, 64'h0, 1'b0);
    end
    drive(1'b1, 2'd2, 1'b0, 2'd1, 16'h5555, 10'h0);
    chk_err("act_b1", 1'b0, 2'd0);
    repeat (4) idle();
    // tCCD: RD b1 three cycles after RD b0 is rejected, four cycles gives contiguous bursts
    for (int c = 0; c <= 13; c++) begin
      if (c == 0) drive(1'b1, 2'd3, 1'b0, 2'd0, 16'h0, 10'h020);
      else if (c == 3 || c == 4) drive(1'b1, 2'd3, 1'b0, 2'd1, 16'h0, 10'h030);
      else idle();
      o = c + 1;
      v = o >= 5 && o <= 12;
      d = o < 9 ? 64'h0000_0000_0042_0020 + 64'(o - 5) : 64'h0000_0001_5555_0030 + 64'(o - 9);
      chk_err("ccd", o == 4, o == 4 ? 2'd2 : 2'd0);
      chk_rd("ccd", v, d, o == 8 || o == 12);
    end
    // write is accepted silently
    drive(1'b1, 2'd3, 1'b1, 2'd0, 16'h0, 10'h001);
    chk_err("wr", 1'b0, 2'd0);
    repeat (8) begin
      idle();
      chk_rd("wr", 1'b0, 64'h0, 1'b0);
    end
    // reset in the middle of a burst
    for (int c = 0; c <= 9; c++) begin
      rst_n = c != 6;
      if (c == 0) drive(1'b1, 2'd3, 1'b0, 2'd0, 16'h0, 10'h040);
      else idle();
      o = c + 1;
      v = o == 5 || o == 6;
      chk_rd("rst_mid", v, 64'h0000_0000_0042_0040 + 64'(o - 5), 1'b0);
    end
    drive(1'b1, 2'd3, 1'b0, 2'd0, 16'h0, 10'h0);
    chk_err("rd_after_rst", 1'b1, 2'd1);
    idle();
    chk_err("final_idle", 1'b0, 2'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
